// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Scan and frame-buffer controller for an 8-digit seven-segment display.
// A prescaler steps the 3-bit digit index Scan. Hex, point and blank data
// are double-buffered so that new data only reaches the outputs on a frame
// boundary, which is the Scan 7->0 step. An optional per-digit blink is
// OR-ed onto LES.
//
// Build option:
//   DISP_SCAN_BLINK_EN - when defined, the blink frame counter, blink phase
//                        and LES overlay are built. When undefined,
//                        LES = le_reg and blink_mask is ignored.
//
// Ports:
//   clk         in   system clock, rising edge
//   rstn        in   asynchronous active-low reset
//   en          in   scan enable; 0 freezes prescaler, Scan and blink state
//   load        in   strobe: capture hex_in/point_in/le_in into pending buffer
//   hex_in      in   [31:0] eight 4-bit digit codes, digit k at [4k+3:4k]
//   point_in    in   [7:0] decimal point per digit
//   le_in       in   [7:0] per-digit blank (1 = blanked)
//   blink_mask  in   [7:0] digits that blink (live, unbuffered)
//   Hexs        out  [31:0] committed digit codes
//   point       out  [7:0] committed points
//   LES         out  [7:0] committed blanks OR blink overlay
//   Scan        out  [2:0] current digit index
//   frame_done  out  one-cycle pulse after each completed frame
//   pending     out  pending buffer holds uncommitted data
module disp_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] hex_in,
  input  logic [7:0]  point_in,
  input  logic [7:0]  le_in,
  input  logic [7:0]  blink_mask,
  output logic [31:0] Hexs,
  output logic [7:0]  point,
  output logic [7:0]  LES,
  output logic [2:0]  Scan,
  output logic        frame_done,
  output logic        pending
);

  localparam int            DW      = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    scan_q, scan_d;
  logic          pending_q, pending_d;
  logic          frame_done_q;
  logic [31:0]   pbuf_hex_q, pbuf_hex_d;
  logic [7:0]    pbuf_pt_q, pbuf_pt_d;
  logic [7:0]    pbuf_le_q, pbuf_le_d;
  logic [31:0]   hexs_q, hexs_d;
  logic [7:0]    point_q, point_d;
  logic [7:0]    le_reg_q, le_reg_d;
  logic          tick, fb, commit;

  assign tick   = en && (div_cnt_q == DIV_MAX);
  assign fb     = tick && (scan_q == 3'd7);
  assign commit = fb && pending_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    scan_d    = scan_q;
    if (tick) begin
      div_cnt_d = '0;
      scan_d    = scan_q + 3'd1;
    end else if (en) begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  // The commit reads the buffer as it stood before this edge, so a load that
  // lands on the boundary cycle refills the buffer and stays pending.
  always_comb begin
    pbuf_hex_d = pbuf_hex_q;
    pbuf_pt_d  = pbuf_pt_q;
    pbuf_le_d  = pbuf_le_q;
    pending_d  = pending_q;
    hexs_d     = hexs_q;
    point_d    = point_q;
    le_reg_d   = le_reg_q;
    if (commit) begin
      hexs_d   = pbuf_hex_q;
      point_d  = pbuf_pt_q;
      le_reg_d = pbuf_le_q;
    end
    if (load) begin
      pbuf_hex_d = hex_in;
      pbuf_pt_d  = point_in;
      pbuf_le_d  = le_in;
      pending_d  = 1'b1;
    end else if (fb) begin
      pending_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_q    <= '0;
      scan_q       <= 3'd0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      pbuf_hex_q   <= 32'h0;
      pbuf_pt_q    <= 8'h00;
      pbuf_le_q    <= 8'hFF;
      hexs_q       <= 32'h0;
      point_q      <= 8'h00;
      le_reg_q     <= 8'hFF;
    end else begin
      div_cnt_q    <= div_cnt_d;
      scan_q       <= scan_d;
      pending_q    <= pending_d;
      frame_done_q <= fb;
      pbuf_hex_q   <= pbuf_hex_d;
      pbuf_pt_q    <= pbuf_pt_d;
      pbuf_le_q    <= pbuf_le_d;
      hexs_q       <= hexs_d;
      point_q      <= point_d;
      le_reg_q     <= le_reg_d;
    end
  end

`ifdef DISP_SCAN_BLINK_EN
  // Width is kept at least 1 so BLINK_FRAMES=1 still has a legal counter;
  // it then sits at 0 and the phase toggles every frame.
  localparam int            FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (fb) begin
      if (frame_cnt_q == FRAME_MAX) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign LES = le_reg_q | (blink_mask & {8{blink_phase_q}});
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign LES = le_reg_q;
`endif

  assign Hexs       = hexs_q;
  assign point      = point_q;
  assign Scan       = scan_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Testbench for disp_scan_ctrl (SCAN_DIV=4, BLINK_FRAMES=2).
// The driver applies inputs on the falling edge and pushes the expected
// post-edge outputs, computed by a cycle-counting reference model, into a
// scoreboard queue; the monitor pops one entry per rising edge and compares.
module tb_disp_scan_ctrl;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] hex_in = 32'h0;
  logic [7:0]  point_in = 8'h00;
  logic [7:0]  le_in = 8'h00;
  logic [7:0]  blink_mask = 8'h00;
  logic [31:0] Hexs;
  logic [7:0]  point, LES;
  logic [2:0]  Scan;
  logic        frame_done, pending;

  disp_scan_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rstn(rstn), .en(en), .load(load),
    .hex_in(hex_in), .point_in(point_in), .le_in(le_in),
    .blink_mask(blink_mask),
    .Hexs(Hexs), .point(point), .LES(LES), .Scan(Scan),
    .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hex;
    logic [7:0]  pt;
    logic [7:0]  les;
    logic [2:0]  scan;
    logic        fd;
    logic        pend;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: everything derives from the number of enabled cycles
  // and completed frames since reset.
  int          m_ecnt, m_frames;
  bit          m_pv, m_fd;
  logic [31:0] m_phex, m_chex;
  logic [7:0]  m_ppt, m_cpt, m_ple, m_cle;
  logic [7:0]  cur_mask = 8'h00;

  task automatic model_reset();
    m_ecnt = 0; m_frames = 0; m_pv = 0; m_fd = 0;
    m_phex = 32'h0; m_ppt = 8'h00; m_ple = 8'hFF;
    m_chex = 32'h0; m_cpt = 8'h00; m_cle = 8'hFF;
  endtask

  function automatic bit at_frame_end();
    return (m_ecnt % FRAME) == FRAME - 1;
  endfunction

  task automatic model_step(input bit e, input bit l, input logic [31:0] h,
                            input logic [7:0] p, input logic [7:0] le);
    bit fb;
    fb = e && at_frame_end();
    if (fb && m_pv) begin
      m_chex = m_phex; m_cpt = m_ppt; m_cle = m_ple;
    end
    if (l) begin
      m_phex = h; m_ppt = p; m_ple = le; m_pv = 1;
    end else if (fb) begin
      m_pv = 0;
    end
    m_fd = fb;
    if (e) m_ecnt++;
    if (fb) m_frames++;
  endtask

  function automatic exp_t model_out(input logic [7:0] mk);
    exp_t x;
    bit   phase;
    phase  = ((m_frames / BF) % 2) == 1;
    x.hex  = m_chex;
    x.pt   = m_cpt;
`ifdef DISP_SCAN_BLINK_EN
    x.les  = m_cle | (phase ? mk : 8'h00);
`else
    phase  = phase & (mk == mk);
    x.les  = m_cle;
`endif
    x.scan = 3'((m_ecnt / SD) % 8);
    x.fd   = m_fd;
    x.pend = m_pv;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  task automatic drive(input bit r, input bit e, input bit l, input logic [31:0] h,
                       input logic [7:0] p, input logic [7:0] le, input logic [7:0] mk);
    @(negedge clk);
    rstn = r; en = e; load = l; hex_in = h; point_in = p; le_in = le; blink_mask = mk;
    if (!r) model_reset();
    else model_step(e, l, h, p, le);
    sb_q.push_back(model_out(mk));
  endtask

  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) drive(1, e, 0, hex_in, point_in, le_in, cur_mask);
  endtask

  task automatic do_load(input logic [31:0] h, input logic [7:0] p, input logic [7:0] le);
    drive(1, 1, 1, h, p, le, cur_mask);
  endtask

  task automatic advance_to_scan(input int s);
    for (int i = 0; i < 2 * FRAME && ((m_ecnt / SD) % 8) != s; i++) idle(1, 1);
  endtask

  task automatic advance_to_fb();
    for (int i = 0; i < 2 * FRAME && !at_frame_end(); i++) idle(1, 1);
  endtask

  task automatic reset_now();
    drive(0, 1, 0, hex_in, point_in, le_in, cur_mask);
    #1;
    chk("rst_scan",  32'(Scan), 32'h0);
    chk("rst_hexs",  Hexs, 32'h0);
    chk("rst_point", 32'(point), 32'h0);
    chk("rst_les",   32'(LES), 32'hFF);
    chk("rst_pend",  32'(pending), 32'h0);
    chk("rst_fd",    32'(frame_done), 32'h0);
  endtask

  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_x = sb_q.pop_front();
      chk("hexs",       Hexs, mon_x.hex);
      chk("point",      32'(point), 32'(mon_x.pt));
      chk("les",        32'(LES), 32'(mon_x.les));
      chk("scan",       32'(Scan), 32'(mon_x.scan));
      chk("frame_done", 32'(frame_done), 32'(mon_x.fd));
      chk("pending",    32'(pending), 32'(mon_x.pend));
    end
  end

  initial begin
    model_reset();
    drive(0, 0, 0, 32'h0, 8'h00, 8'h00, 8'h00);
    drive(0, 0, 0, 32'h0, 8'h00, 8'h00, 8'h00);
    idle(70, 1);

    // deferred commit while Scan=3
    advance_to_scan(3);
    do_load(32'h12345678, 8'h5A, 8'h00);
    idle(40, 1);

    // overwrite within one frame
    advance_to_scan(1);
    do_load(32'hAAAA0000, 8'h0F, 8'h0F);
    idle(2, 1);
    do_load(32'h0000BBBB, 8'hC3, 8'h00);
    idle(40, 1);

    // en drop stretches the current step
    advance_to_scan(2);
    idle(1, 1);
    idle(10, 0);
    idle(10, 1);

    // load on the boundary cycle with nothing pending
    advance_to_fb();
    do_load(32'h22222222, 8'h01, 8'h00);
    idle(70, 1);

    // load on the boundary cycle with data pending
    advance_to_scan(2);
    do_load(32'h11111111, 8'h02, 8'h00);
    advance_to_fb();
    do_load(32'h22222222, 8'h04, 8'h00);
    idle(70, 1);

    // load arrives while disabled on what would be the boundary cycle
    advance_to_fb();
    drive(1, 0, 1, 32'h33333333, 8'h08, 8'h10, cur_mask);
    idle(5, 0);
    idle(40, 1);

    // blink on digit 0
    cur_mask = 8'h01;
    do_load(32'h44444444, 8'h00, 8'h00);
    idle(200, 1);

    // reset mid-frame with data pending
    advance_to_scan(5);
    do_load(32'h55555555, 8'hFF, 8'h00);
    reset_now();
    drive(0, 1, 0, hex_in, point_in, le_in, cur_mask);
    idle(40, 1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_now();
      end else begin
        if ($urandom_range(0, 49) == 0) cur_mask = 8'($urandom);
        drive(1, $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
              $urandom, 8'($urandom), 8'($urandom), cur_mask);
      end
    end
    idle(2, 1);

    @(posedge clk);
    #3;
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan and frame-buffer controller for the 8-digit seven-segment display path. It generates the 3-bit `Scan` digit index, double-buffers the hex, point and LE data so that updates take effect only on a frame boundary, and overlays a per-digit blink onto `LES`. Its `Hexs`, `point`, `LES` and `Scan` outputs drive the digit-select/mux stage directly.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: enabled clock cycles per scan step (≥2).
- `BLINK_FRAMES`, default 32: complete frames per blink half-period (≥1).

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `en` in 1: scan enable; 0 freezes the prescaler, `Scan` and the blink state.
- `load` in 1: single-cycle strobe that captures `hex_in`, `point_in` and `le_in` into the pending buffer.
- `hex_in` in 32: eight 4-bit digit codes; digit k is bits [4k+3:4k].
- `point_in` in 8: decimal point per digit.
- `le_in` in 8: per-digit blank (1 = digit blanked downstream).
- `blink_mask` in 8: digits that blink; unbuffered, sampled live.
- `Hexs` out 32: committed digit codes.
- `point` out 8: committed points.
- `LES` out 8: committed blanks OR blink overlay.
- `Scan` out 3: current digit index.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `pending` out 1: pending buffer holds uncommitted data.

## Operation
- Prescaler `div_cnt` counts 0..SCAN_DIV-1 while `en`=1. `tick` is asserted when `div_cnt`==SCAN_DIV-1 and `en`=1. On `tick`, `div_cnt` wraps to 0 and `Scan` increments modulo 8.
- Frame boundary `fb` = `tick` && `Scan`==7.
- Load: when `load`=1, the pending buffer takes the current `hex_in`, `point_in` and `le_in`, and `pending` is set. Repeated loads before a commit overwrite the buffer; the last load wins.
- Commit: on `fb` with `pending`=1, `Hexs`, `point` and `le_reg` take the pending buffer contents.
  - `pending` clears unless `load` is also asserted in that cycle.
  - If `load` coincides with `fb`, the commit uses the buffer contents from before that edge. The new load data stays pending (`pending`=1) and commits at the next boundary.
  - On `fb` with `pending`=0, nothing is committed.
- Blink: `frame_cnt` counts 0..BLINK_FRAMES-1, advancing on each `fb`. On wrap, `blink_phase` toggles.
- Output: `LES` = `le_reg` | (`blink_mask` & {8{`blink_phase`}}). This is combinational from registers plus `blink_mask`.
- `en`=0 holds all counters and `blink_phase`. `load` still captures into the pending buffer, but no commit happens while `en`=0.

## Timing
- Reset values:
  - `div_cnt`=0, `Scan`=0, `frame_cnt`=0, `blink_phase`=0.
  - `pending`=0, `frame_done`=0.
  - `Hexs`=32'h0, `point`=8'h00, `le_reg`=8'hFF, so `LES`=8'hFF (all digits blank until the first commit).
- `Scan` holds each value for exactly SCAN_DIV enabled cycles. A full frame takes 8·SCAN_DIV enabled cycles.
- Commit latency: outputs change on the same edge where `Scan` goes 7→0. From `load`, latency is at most one frame plus one cycle.
- `frame_done` is registered. It is high for exactly the single cycle following the `fb` edge, which is the first cycle in which `Scan` reads 0.
- `blink_phase` toggles on the `fb` edge that wraps `frame_cnt`. One blink half-period is BLINK_FRAMES·8·SCAN_DIV enabled cycles.
- Reset asserted mid-frame clears all state immediately and asynchronously, including pending data. After release, scanning restarts at `Scan`=0 with a full SCAN_DIV count.
- `en` deasserted on a cycle where `tick` would fire: no tick and no step.

## Configuration
- `DISP_SCAN_BLINK_EN` defined: the blink logic (`frame_cnt`, `blink_phase`, overlay) is present as described above.
- `DISP_SCAN_BLINK_EN` undefined: the blink logic is removed; `LES` = `le_reg`, `blink_mask` is ignored, and everything else is unchanged.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_FRAMES=2 unless stated.
- Reset: assert `rstn`=0 mid-run -> immediately `Scan`=0, `Hexs`=0, `point`=0, `LES`=8'hFF, `pending`=0, `frame_done`=0.
- Scan stepping: `en`=1 from reset -> `Scan` steps 0,1,…,7,0 every 4 cycles; `frame_done` pulses once every 32 cycles, coincident with the first `Scan`=0 cycle. Dropping `en` for 10 cycles stretches the current step by 10.
- Deferred commit: `load` with `hex_in`=32'h12345678, `le_in`=8'h00 while `Scan`=3 -> `Hexs` and `LES` unchanged and `pending`=1 until the 7→0 edge, then `Hexs`=32'h12345678, `LES`=8'h00, `pending`=0.
- Overwrite: load 32'hAAAA0000, then 32'h0000BBBB in the same frame -> commit shows 32'h0000BBBB.
- Boundary collision: first with `pending`=0, then with `pending`=1 holding 32'h11111111, pulse `load` (32'h22222222) in the `fb` cycle.
  - `pending`=0 case -> no commit at this boundary; 32'h22222222 commits 32 cycles later.
  - `pending`=1 case -> 32'h11111111 commits now, `pending` stays 1, and 32'h22222222 commits at the next boundary.
- Blink: `le_in`=0 committed, `blink_mask`=8'h01 -> `LES[0]` toggles every 64 cycles and `LES[7:1]`=0. With `DISP_SCAN_BLINK_EN` undefined -> `LES`=8'h00 constant.
